// File: rtl/uart_rx_core_pkg.sv
// rtl/uart_rx_core_pkg.sv - UART receiver state encodings, default line settings, baud divider helper
package uart_rx_core_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

  localparam int DEFAULT_CLK_FREQ   = 100_000_000;
  localparam int DEFAULT_BAUD       = 9600;
  localparam int DEFAULT_OVERSAMPLE = 16;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
    int den;
    den = baud * oversample;
    return (clk_freq + den / 2) / den;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - free-running oversample tick generator, shared with the TX side
module uart_baud_tick
  import uart_rx_core_pkg::*;
#(
  parameter int CLK_FREQ   = DEFAULT_CLK_FREQ,
  parameter int BAUD       = DEFAULT_BAUD,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CNT_LAST);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - 8N1 UART receiver, 16x oversampled, mid-bit sampling, false-start and framing checks
module uart_rx_core
  import uart_rx_core_pkg::*;
#(
  parameter int CLK_FREQ   = DEFAULT_CLK_FREQ,
  parameter int BAUD       = DEFAULT_BAUD,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam logic [3:0] MID_TICK  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);

  logic       tick;
  logic       sync1_q, sync2_q;
  logic       rx_s;
  rx_state_e  state_q, state_d;
  logic [3:0] tick_cnt_q, tick_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_done_q, rx_done_d;
  logic       frame_err_q, frame_err_d;
  logic       rx_busy_q, rx_busy_d;

  uart_baud_tick #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  assign rx_s = sync2_q;

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_done_d   = 1'b0;
    frame_err_d = 1'b0;
    rx_busy_d   = rx_busy_q;
    unique case (state_q)
      ST_IDLE: begin
        rx_busy_d = 1'b0;
        if (!rx_s) begin
          state_d    = ST_START;
          tick_cnt_d = '0;
          rx_busy_d  = 1'b1;
        end
      end
      ST_START: if (tick) begin
        if (tick_cnt_q == MID_TICK) begin
          if (rx_s) begin
            state_d   = ST_IDLE;
            rx_busy_d = 1'b0;
          end else begin
            state_d    = ST_DATA;
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
          end
        end else begin
          tick_cnt_d = tick_cnt_q + 4'd1;
        end
      end
      ST_DATA: if (tick) begin
        if (tick_cnt_q == LAST_TICK) begin
          shift_d    = {rx_s, shift_q[7:1]};
          tick_cnt_d = '0;
          if (bit_cnt_q == 3'd7) state_d = ST_STOP;
          else                   bit_cnt_d = bit_cnt_q + 3'd1;
        end else begin
          tick_cnt_d = tick_cnt_q + 4'd1;
        end
      end
      ST_STOP: if (tick) begin
        if (tick_cnt_q == LAST_TICK) begin
          if (rx_s) begin
            rx_data_d = shift_q;
            rx_done_d = 1'b1;
            state_d   = ST_IDLE;
            rx_busy_d = 1'b0;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_BREAK;
          end
        end else begin
          tick_cnt_d = tick_cnt_q + 4'd1;
        end
      end
      // Held-low line after a bad stop bit must not look like a new start.
      ST_BREAK: if (rx_s) begin
        state_d   = ST_IDLE;
        rx_busy_d = 1'b0;
      end
      default: begin
        state_d   = ST_IDLE;
        rx_busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= ST_IDLE;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
      rx_busy_q   <= 1'b0;
    end else begin
      sync1_q     <= rx;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
      rx_busy_q   <= rx_busy_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_done   = rx_done_q;
  assign frame_err = frame_err_q;
  assign rx_busy   = rx_busy_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - directed bench for uart_rx_core: fast-baud instance A, 115200-baud instance B
module tb_uart_rx_core;

  localparam int BIT_A = 1600;  // 625 kbaud at 100 MHz: DIV=10, 16 ticks of 100 ns
  localparam int BIT_B = 8681;  // 115200 baud
  localparam int LAT_A = 15200; // 9.5 bit times, A
  localparam int LAT_B = 82080; // 9.5 * 16 * 54 * 10 ns, B

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_a = 1'b1;
  logic       rx_b = 1'b1;
  logic [7:0] rx_data_a, rx_data_b;
  logic       rx_done_a, rx_done_b;
  logic       frame_err_a, frame_err_b;
  logic       rx_busy_a, rx_busy_b;

  int checks = 0;
  int failures = 0;

  int  done_a_cnt = 0, ferr_a_cnt = 0, done_a_dbl = 0, ferr_a_dbl = 0;
  int  done_b_cnt = 0, ferr_b_cnt = 0;
  time done_a_t = 0, done_b_t = 0;
  logic done_a_prev = 1'b0, ferr_a_prev = 1'b0;

  always #5 clk = ~clk;

  uart_rx_core #(.CLK_FREQ(100_000_000), .BAUD(625_000), .OVERSAMPLE(16)) dut_a (
    .clk(clk), .rst(rst), .rx(rx_a), .rx_data(rx_data_a),
    .rx_done(rx_done_a), .frame_err(frame_err_a), .rx_busy(rx_busy_a)
  );

  uart_rx_core #(.CLK_FREQ(100_000_000), .BAUD(115_200), .OVERSAMPLE(16)) dut_b (
    .clk(clk), .rst(rst), .rx(rx_b), .rx_data(rx_data_b),
    .rx_done(rx_done_b), .frame_err(frame_err_b), .rx_busy(rx_busy_b)
  );

  always @(negedge clk) begin
    done_a_prev <= rx_done_a;
    ferr_a_prev <= frame_err_a;
    if (rx_done_a) begin
      done_a_cnt <= done_a_cnt + 1;
      done_a_t   <= $time;
    end
    if (frame_err_a) ferr_a_cnt <= ferr_a_cnt + 1;
    if (rx_done_a && done_a_prev) done_a_dbl <= done_a_dbl + 1;
    if (frame_err_a && ferr_a_prev) ferr_a_dbl <= ferr_a_dbl + 1;
    if (rx_done_b) begin
      done_b_cnt <= done_b_cnt + 1;
      done_b_t   <= $time;
    end
    if (frame_err_b) ferr_b_cnt <= ferr_b_cnt + 1;
  end

  task automatic send_bits_a(input logic [7:0] d);
    rx_a = 1'b0;
    #(BIT_A);
    for (int i = 0; i < 8; i++) begin
      rx_a = d[i];
      #(BIT_A);
    end
  endtask

  task automatic send_a(input logic [7:0] d, input logic stop);
    send_bits_a(d);
    rx_a = stop;
    #(BIT_A);
    rx_a = 1'b1;
  endtask

  task automatic expect_frame_a(input logic [7:0] d, input string name);
    int d0, f0;
    d0 = done_a_cnt;
    f0 = ferr_a_cnt;
    send_a(d, 1'b1);
    #(BIT_A);
    checks++;
    if (done_a_cnt - d0 !== 1 || ferr_a_cnt - f0 !== 0) begin
      failures++;
      $display("FAIL %s_pulses: done=%0d ferr=%0d expected done=1 ferr=0", name, done_a_cnt - d0, ferr_a_cnt - f0);
    end
    checks++;
    if (rx_data_a !== d) begin
      failures++;
      $display("FAIL %s_data: got %h expected %h", name, rx_data_a, d);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (rx_data_a !== 8'h00 || rx_done_a !== 1'b0 || frame_err_a !== 1'b0 || rx_busy_a !== 1'b0) begin
      failures++;
      $display("FAIL reset_a: data=%h done=%b ferr=%b busy=%b expected 00 0 0 0", rx_data_a, rx_done_a, frame_err_a, rx_busy_a);
    end
    checks++;
    if (rx_data_b !== 8'h00 || rx_done_b !== 1'b0 || frame_err_b !== 1'b0 || rx_busy_b !== 1'b0) begin
      failures++;
      $display("FAIL reset_b: data=%h done=%b ferr=%b busy=%b expected 00 0 0 0", rx_data_b, rx_done_b, frame_err_b, rx_busy_b);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_single;
    time t0;
    int  dbl0;
    dbl0 = done_a_dbl;
    t0 = $time;
    expect_frame_a(8'h30, "single");
    checks++;
    if (done_a_t < t0 + LAT_A - 120 || done_a_t > t0 + LAT_A + 60) begin
      failures++;
      $display("FAIL single_latency: got %0t ns after start, expected %0d ns (-120/+60)", done_a_t - t0, LAT_A);
    end
    checks++;
    if (done_a_dbl !== dbl0) begin
      failures++;
      $display("FAIL single_pulse_width: rx_done held %0d extra cycles, expected 0", done_a_dbl - dbl0);
    end
  endtask

  task automatic test_back_to_back;
    int d0;
    d0 = done_a_cnt;
    send_bits_a(8'h31);
    rx_a = 1'b1;
    for (int i = 0; i < 400 && rx_done_a !== 1'b1; i++) @(negedge clk);
    checks++;
    if (rx_done_a !== 1'b1 || rx_data_a !== 8'h31) begin
      failures++;
      $display("FAIL b2b_first: done=%b data=%h expected done=1 data=31", rx_done_a, rx_data_a);
    end
    send_a(8'h32, 1'b1);
    #(BIT_A);
    checks++;
    if (done_a_cnt - d0 !== 2 || rx_data_a !== 8'h32) begin
      failures++;
      $display("FAIL b2b_second: pulses=%0d data=%h expected pulses=2 data=32", done_a_cnt - d0, rx_data_a);
    end
  endtask

  task automatic test_false_start;
    int d0, f0;
    d0 = done_a_cnt;
    f0 = ferr_a_cnt;
    rx_a = 1'b0;
    #300;
    rx_a = 1'b1;
    checks++;
    if (rx_busy_a !== 1'b1) begin
      failures++;
      $display("FAIL glitch_busy_set: got %b expected 1", rx_busy_a);
    end
    #(BIT_A - 300);
    checks++;
    if (rx_busy_a !== 1'b0 || done_a_cnt !== d0 || ferr_a_cnt !== f0) begin
      failures++;
      $display("FAIL glitch_reject: busy=%b done=%0d ferr=%0d expected 0 0 0", rx_busy_a, done_a_cnt - d0, ferr_a_cnt - f0);
    end
    expect_frame_a(8'hA5, "after_glitch");
  endtask

  task automatic test_frame_err;
    int d0, f0, fd0;
    expect_frame_a(8'h30, "pre_ferr");
    d0 = done_a_cnt;
    f0 = ferr_a_cnt;
    fd0 = ferr_a_dbl;
    send_bits_a(8'h55);
    rx_a = 1'b0;
    #(3 * BIT_A);
    checks++;
    if (rx_busy_a !== 1'b1) begin
      failures++;
      $display("FAIL break_busy: got %b expected 1 while line held low", rx_busy_a);
    end
    rx_a = 1'b1;
    #(BIT_A);
    checks++;
    if (ferr_a_cnt - f0 !== 1 || done_a_cnt !== d0 || ferr_a_dbl !== fd0) begin
      failures++;
      $display("FAIL ferr_pulses: ferr=%0d done=%0d wide=%0d expected 1 0 0", ferr_a_cnt - f0, done_a_cnt - d0, ferr_a_dbl - fd0);
    end
    checks++;
    if (rx_data_a !== 8'h30 || rx_busy_a !== 1'b0) begin
      failures++;
      $display("FAIL ferr_hold: data=%h busy=%b expected 30 0", rx_data_a, rx_busy_a);
    end
    expect_frame_a(8'hC3, "after_ferr");
  endtask

  task automatic test_reset_mid_frame;
    int d0, f0;
    d0 = done_a_cnt;
    f0 = ferr_a_cnt;
    rx_a = 1'b0;
    #(BIT_A);
    rx_a = 1'b1;
    #(4 * BIT_A + BIT_A / 2);
    rst = 1'b1;
    #1;
    checks++;
    if (rx_data_a !== 8'h00 || rx_done_a !== 1'b0 || frame_err_a !== 1'b0 || rx_busy_a !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: data=%h done=%b ferr=%b busy=%b expected 00 0 0 0", rx_data_a, rx_done_a, frame_err_a, rx_busy_a);
    end
    #99;
    rst = 1'b0;
    #(BIT_A / 2 + 5 * BIT_A);
    checks++;
    if (done_a_cnt !== d0 || ferr_a_cnt !== f0) begin
      failures++;
      $display("FAIL mid_reset_no_pulse: done=%0d ferr=%0d expected 0 0", done_a_cnt - d0, ferr_a_cnt - f0);
    end
    expect_frame_a(8'h0F, "after_reset");
  endtask

  task automatic test_div_115200;
    time t0;
    int  d0, f0;
    logic [7:0] d;
    d = 8'h7E;
    d0 = done_b_cnt;
    f0 = ferr_b_cnt;
    t0 = $time;
    rx_b = 1'b0;
    #(BIT_B);
    for (int i = 0; i < 8; i++) begin
      rx_b = d[i];
      #(BIT_B);
    end
    rx_b = 1'b1;
    #(2 * BIT_B);
    checks++;
    if (done_b_cnt - d0 !== 1 || ferr_b_cnt !== f0 || rx_data_b !== 8'h7E) begin
      failures++;
      $display("FAIL div_frame: done=%0d ferr=%0d data=%h expected 1 0 7e", done_b_cnt - d0, ferr_b_cnt - f0, rx_data_b);
    end
    checks++;
    if (done_b_t < t0 + LAT_B - 600 || done_b_t > t0 + LAT_B + 60) begin
      failures++;
      $display("FAIL div_latency: got %0t ns after start, expected %0d ns (-600/+60)", done_b_t - t0, LAT_B);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_false_start();
    test_frame_err();
    test_reset_mid_frame();
    test_div_115200();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
